sec_decode_scheduler: RTL and testbench

- Shares one multi-cycle SEC decoder (61-bit codeword in, 53-bit data out, `found` completion flag) between NUM_REQ requesters.
- Arbitrates round-robin and loads the granted codeword into the decoder.
- Re-arms the decoder through its reset, waits for `found`, then returns the result tagged with the requester ID over a valid/ready response channel.
- Sits between the bus-side request queues and the decoder instance.

---
 rtl/sec_sched_pkg.sv | 23 ++
 rtl/sec_rr_arbiter.sv | 45 ++++
 rtl/sec_decode_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_sec_decode_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sec_sched_pkg.sv
// Shared definitions for the SEC decoder scheduler slice.
//   sched_state_e : scheduler FSM states (IDLE/ARM/WAIT/RESP)
//   DEF_W_BITS    : default codeword width
//   DEF_N_BITS    : default decoded data width
//   id_width()    : requester ID width for a given requester count
package sec_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } sched_state_e;

    localparam int DEF_W_BITS = 61;
    localparam int DEF_N_BITS = 53;

    // A single requester still needs a 1-bit ID field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sec_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req_valid_i starting at rr_ptr_i and wrapping upward; the first
// set bit wins. Shared by the decoder schedulers.
//   req_valid_i : request vector
//   rr_ptr_i    : index with the highest priority this cycle
//   en_i        : grant enable; no grant when low
//   gnt_oh_o    : one-hot grant (zero if none)
//   gnt_idx_o   : binary index of the grant (0 if none)
//   gnt_any_o   : a grant was issued
module sec_rr_arbiter
    import sec_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [ID_W-1:0]    gnt_idx_o,
    output logic               gnt_any_o
);

    int idx;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Candidate index wraps past the top requester back to 0.
            idx = int'(rr_ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (en_i && !gnt_any_o && req_valid_i[idx]) begin
                gnt_any_o     = 1'b1;
                gnt_oh_o[idx] = 1'b1;
                gnt_idx_o     = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sec_decode_scheduler.sv
// Shares one multi-cycle SEC decoder between NUM_REQ requesters.
// A round-robin grant loads one codeword into the decoder, the decoder is
// re-armed through its reset for one cycle, the scheduler waits for `found`
// and returns the decoded data tagged with the requester ID.
// Only one codeword is in flight at a time.
//
// Optional build macro SEC_TIMEOUT_EN: adds a WAIT watchdog of TIMEOUT_CYC
// cycles that returns rsp_err=1 / rsp_n=0 if the decoder never finds.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready one-hot or 0)
//   req_w                 codewords, requester i at [i*W_BITS +: W_BITS]
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_n, rsp_err response owner, decoded data, watchdog error
//   dec_w, dec_rst_n      codeword and active-low re-arm to the decoder
//   dec_found, dec_n      decoder completion and result
//   busy                  scheduler not in IDLE
module sec_decode_scheduler
    import sec_sched_pkg::*;
#(
    parameter  int W_BITS      = DEF_W_BITS,
    parameter  int N_BITS      = DEF_N_BITS,
    parameter  int NUM_REQ     = 4,
    parameter  int TIMEOUT_CYC = 64,
    localparam int ID_W        = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*W_BITS-1:0] req_w,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [N_BITS-1:0]         rsp_n,
    output logic                      rsp_err,
    output logic [W_BITS-1:0]         dec_w,
    output logic                      dec_rst_n,
    input  logic                      dec_found,
    input  logic [N_BITS-1:0]         dec_n,
    output logic                      busy
);

    sched_state_e        state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [W_BITS-1:0]   dec_w_q, dec_w_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [N_BITS-1:0]   rsp_n_q, rsp_n_d;
    logic                rsp_err_q, rsp_err_d;
    logic                arm_n_q, arm_n_d;

    logic [NUM_REQ-1:0]  gnt_oh;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_any;
    logic                arb_en;
    logic                timeout;

    // Gated by rst_n so req_ready is 0 for the whole reset interval.
    assign arb_en = rst_n && (state_q == ST_IDLE);

    sec_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .en_i        (arb_en),
        .gnt_oh_o    (gnt_oh),
        .gnt_idx_o   (gnt_idx),
        .gnt_any_o   (gnt_any)
    );

`ifdef SEC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Counter holds the number of WAIT cycles already completed, so the
    // TIMEOUT_CYC-th WAIT cycle is the one that gives up.
    assign timeout = (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_ARM) begin
            wait_cnt_d = '0;
        end else if (state_q == ST_WAIT && wait_cnt_q != CNT_W'(TIMEOUT_CYC)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        dec_w_d   = dec_w_q;
        rsp_id_d  = rsp_id_q;
        rsp_n_d   = rsp_n_q;
        rsp_err_d = rsp_err_q;
        arm_n_d   = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (gnt_oh[i]) begin
                            dec_w_d = req_w[i*W_BITS +: W_BITS];
                        end
                    end
                    rsp_id_d  = gnt_idx;
                    rsp_err_d = 1'b0;
                    rr_ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                    // Registered so dec_rst_n is a clean one-cycle low in ARM.
                    arm_n_d   = 1'b0;
                    state_d   = ST_ARM;
                end
            end
            ST_ARM: begin
                // `found` may still be high from the previous word; not sampled here.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (dec_found) begin
                    rsp_n_d   = dec_n;
                    rsp_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (timeout) begin
                    rsp_n_d   = '0;
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            dec_w_q   <= '0;
            rsp_id_q  <= '0;
            rsp_n_q   <= '0;
            rsp_err_q <= 1'b0;
            arm_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            dec_w_q   <= dec_w_d;
            rsp_id_q  <= rsp_id_d;
            rsp_n_q   <= rsp_n_d;
            rsp_err_q <= rsp_err_d;
            arm_n_q   <= arm_n_d;
        end
    end

    assign req_ready = gnt_oh;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_n     = rsp_n_q;
    assign rsp_err   = rsp_err_q;
    assign dec_w     = dec_w_q;
    // Decoder is also held in reset while the scheduler itself is reset.
    assign dec_rst_n = rst_n & arm_n_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sec_decode_scheduler.sv
module tb_sec_decode_scheduler;

    localparam int NR  = 4;
    localparam int WB  = 61;
    localparam int NB  = 53;
    localparam int IDW = 2;
    localparam logic [NB-1:0] K = 53'h0_5A5A_5A5A_5A5A;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*WB-1:0] req_w;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [NB-1:0]    rsp_n;
    logic             rsp_err;
    logic [WB-1:0]    dec_w;
    logic             dec_rst_n;
    logic             dec_found;
    logic [NB-1:0]    dec_n;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Bench decoder model
    int          delay;
    int          mcnt;
    bit          model_en;
    bit          xform;
    bit          manual;
    bit          man_found;
    logic [NB-1:0] model_n;
    logic [NB-1:0] man_n;

    sec_decode_scheduler #(
        .W_BITS      (WB),
        .N_BITS      (NB),
        .NUM_REQ     (NR),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_w     (req_w),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_n     (rsp_n),
        .rsp_err   (rsp_err),
        .dec_w     (dec_w),
        .dec_rst_n (dec_rst_n),
        .dec_found (dec_found),
        .dec_n     (dec_n),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counts cycles since the decoder left reset; found is raised in the
    // delay-th cycle with dec_rst_n high and stays high until the next re-arm.
    always @(posedge clk) begin
        if (!dec_rst_n) mcnt <= 0;
        else if (mcnt < 100000) mcnt <= mcnt + 1;
    end

    always_comb begin
        dec_found = 1'b0;
        dec_n     = model_n;
        if (manual) begin
            dec_found = man_found;
            dec_n     = man_n;
        end else begin
            dec_found = model_en && dec_rst_n && (mcnt + 1 >= delay);
            dec_n     = xform ? (dec_w[NB-1:0] ^ K) : model_n;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_w = '0; rsp_ready = 1'b0;
        model_en = 1'b1; xform = 1'b0; manual = 1'b0; man_found = 1'b0;
        man_n = '0; model_n = '0; delay = 1;
        #2;
        req_valid = 4'hF;
        step();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got valid=%b busy=%b err=%b expected 0 0 0", rsp_valid, busy, rsp_err); end
        checks++; if (rsp_id !== 2'd0 || rsp_n !== '0 || dec_w !== '0) begin errors++; $display("FAIL reset_data: got id=%0h n=%0h w=%0h expected 0 0 0", rsp_id, rsp_n, dec_w); end
        checks++; if (dec_rst_n !== 1'b0) begin errors++; $display("FAIL reset_dec_rst_n: got %b expected 0", dec_rst_n); end
        req_valid = '0;
        rst_n = 1'b1;
        #1;
        checks++; if (dec_rst_n !== 1'b1) begin errors++; $display("FAIL reset_release_dec_rst_n: got %b expected 1", dec_rst_n); end
        step();
    endtask

    task automatic test_single();
        int tacc, lows, got, lat;
        req_w[2*WB +: WB] = 61'h1;
        model_n = 53'h1F_FFFF_FFFF_FFFF; xform = 1'b0; delay = 5; model_en = 1'b1;
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", req_ready); end
        tacc = cyc;
        step();
        req_valid = '0;
        checks++; if (req_ready !== 4'b0000 || busy !== 1'b1 || dec_w !== 61'h1) begin errors++; $display("FAIL single_arm: got ready=%b busy=%b w=%0h expected 0000 1 1", req_ready, busy, dec_w); end
        lows = 0; got = 0;
        for (int c = 0; c < 40; c++) begin
            if (!dec_rst_n) lows++;
            if (rsp_valid) begin got = 1; break; end
            step();
        end
        lat = cyc - tacc;
        checks++; if (got != 1) begin errors++; $display("FAIL single_rsp_timeout: got no rsp_valid expected one within 40 cycles"); end
        checks++; if (lat != 7) begin errors++; $display("FAIL single_latency: got %0d expected 7", lat); end
        checks++; if (lows != 1) begin errors++; $display("FAIL single_dec_rst_low: got %0d cycles expected 1", lows); end
        checks++; if (rsp_id !== 2'd2 || rsp_n !== 53'h1F_FFFF_FFFF_FFFF || rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp: got id=%0d n=%0h err=%b expected 2 1fffffffffffff 0", rsp_id, rsp_n, rsp_err); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
    endtask

    task automatic test_round_robin();
        logic [WB-1:0] cws [NR];
        int exp_ord [5];
        int grants [8];
        int ng, nr, first_acc, first_rsp, gi;
        logic [NB-1:0] expn;
        exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 2; exp_ord[3] = 3; exp_ord[4] = 0;
        for (int i = 0; i < NR; i++) begin
            cws[i] = 61'h0123_4567_89AB_CDE0 + 61'(i * 61'h11_1111);
            req_w[i*WB +: WB] = cws[i];
        end
        do_reset();
        xform = 1'b1; delay = 1; model_en = 1'b1; rsp_ready = 1'b1;
        req_valid = 4'hF;
        ng = 0; nr = 0; first_acc = -1; first_rsp = -1;
        #1;
        for (int c = 0; c < 100 && nr < 5; c++) begin
            if (req_ready != 0 && ng < 8) begin
                gi = -1;
                for (int b = 0; b < NR; b++) if (req_ready[b]) gi = b;
                grants[ng] = gi;
                if (ng == 0) first_acc = cyc;
                ng++;
            end
            if (rsp_valid) begin
                expn = cws[exp_ord[nr]][NB-1:0] ^ K;
                checks++; if (rsp_id !== IDW'(exp_ord[nr]) || rsp_n !== expn) begin errors++; $display("FAIL rr_rsp%0d: got id=%0d n=%0h expected %0d %0h", nr, rsp_id, rsp_n, exp_ord[nr], expn); end
                if (nr == 0) first_rsp = cyc;
                nr++;
                if (nr == 5) req_valid = '0;
            end
            step();
        end
        rsp_ready = 1'b0;
        checks++; if (nr != 5 || ng != 5) begin errors++; $display("FAIL rr_count: got rsp=%0d grants=%0d expected 5 5", nr, ng); end
        for (int i = 0; i < 5 && i < ng; i++) begin
            checks++; if (grants[i] != exp_ord[i]) begin errors++; $display("FAIL rr_grant%0d: got %0d expected %0d", i, grants[i], exp_ord[i]); end
        end
        checks++; if (first_rsp - first_acc != 3) begin errors++; $display("FAIL rr_first_latency: got %0d expected 3", first_rsp - first_acc); end
    endtask

    task automatic test_backpressure();
        logic [WB-1:0] cw;
        logic [NB-1:0] expn;
        int got;
        cw = 61'h1ABC_DEF0_1234_5678;
        req_w[0 +: WB] = cw;
        expn = cw[NB-1:0] ^ K;
        xform = 1'b1; delay = 3; rsp_ready = 1'b0;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant: got %b expected 0001", req_ready); end
        step();
        req_valid = 4'hF;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            if (rsp_valid) begin got = 1; break; end
            step();
        end
        checks++; if (got != 1 || rsp_id !== 2'd0 || rsp_n !== expn) begin errors++; $display("FAIL bp_rsp: got valid=%0d id=%0d n=%0h expected 1 0 %0h", got, rsp_id, rsp_n, expn); end
        for (int c = 0; c < 10; c++) begin
            step();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_n !== expn) begin errors++; $display("FAIL bp_hold%0d: got valid=%b id=%0d n=%0h expected 1 0 %0h", c, rsp_valid, rsp_id, rsp_n, expn); end
            checks++; if (req_ready !== 4'b0000 || dec_rst_n !== 1'b1) begin errors++; $display("FAIL bp_quiet%0d: got ready=%b dec_rst_n=%b expected 0000 1", c, req_ready, dec_rst_n); end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_bypass: got %b expected 0000", req_ready); end
        step();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin errors++; $display("FAIL bp_next_grant: got valid=%b ready=%b expected 0 0010", rsp_valid, req_ready); end
        req_valid = '0;
        step();
    endtask

    task automatic test_stale_found();
        manual = 1'b1; man_found = 1'b1; man_n = 53'h0_DEAD_DEAD_DEAD;
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL stale_grant: got %b expected 1000", req_ready); end
        step();
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b0 || dec_rst_n !== 1'b0) begin errors++; $display("FAIL stale_arm: got valid=%b dec_rst_n=%b expected 0 0", rsp_valid, dec_rst_n); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stale_wait1: got valid=%b expected 0", rsp_valid); end
        man_found = 1'b0;
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stale_wait2: got valid=%b expected 0", rsp_valid); end
        man_found = 1'b1; man_n = 53'h0_0BEE_F0BE_EF01;
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_n !== 53'h0_0BEE_F0BE_EF01) begin errors++; $display("FAIL stale_rsp: got valid=%b id=%0d n=%0h expected 1 3 beef0beef01", rsp_valid, rsp_id, rsp_n); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0; manual = 1'b0; man_found = 1'b0;
    endtask

    task automatic test_async_reset();
        model_en = 1'b0;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ar_grant: got %b expected 0100", req_ready); end
        step();
        req_valid = '0;
        step();
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_busy: got %b expected 1", busy); end
        req_valid = 4'b1010;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000 || dec_rst_n !== 1'b0) begin errors++; $display("FAIL ar_ctrl: got busy=%b valid=%b ready=%b dec_rst_n=%b expected 0 0 0000 0", busy, rsp_valid, req_ready, dec_rst_n); end
        checks++; if (dec_w !== '0 || rsp_id !== 2'd0 || rsp_n !== '0 || rsp_err !== 1'b0) begin errors++; $display("FAIL ar_data: got w=%0h id=%0d n=%0h err=%b expected 0 0 0 0", dec_w, rsp_id, rsp_n, rsp_err); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010 || dec_rst_n !== 1'b1) begin errors++; $display("FAIL ar_regrant: got ready=%b dec_rst_n=%b expected 0010 1", req_ready, dec_rst_n); end
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ar_quiet%0d: got valid=%b busy=%b expected 0 0", c, rsp_valid, busy); end
        end
        model_en = 1'b1;
    endtask

    task automatic test_no_found();
        int tacc;
`ifdef SEC_TIMEOUT_EN
        int got;
`else
        int bad;
`endif
        model_en = 1'b0; rsp_ready = 1'b0;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL nf_grant: got %b expected 0001", req_ready); end
        tacc = cyc;
        step();
        req_valid = '0;
`ifdef SEC_TIMEOUT_EN
        got = 0;
        for (int c = 0; c < 200; c++) begin
            if (rsp_valid) begin got = 1; break; end
            step();
        end
        checks++; if (got != 1 || cyc - tacc != 66) begin errors++; $display("FAIL to_latency: got valid=%0d lat=%0d expected 1 66", got, cyc - tacc); end
        checks++; if (rsp_err !== 1'b1 || rsp_n !== '0 || rsp_id !== 2'd0) begin errors++; $display("FAIL to_rsp: got err=%b n=%0h id=%0d expected 1 0 0", rsp_err, rsp_n, rsp_id); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_done: got busy=%b expected 0", busy); end
`else
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            if (!busy || rsp_valid) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL nf_stuck: got %0d bad cycles expected 0", bad); end
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL nf_final: got busy=%b valid=%b expected 1 0", busy, rsp_valid); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_stale_found();
        test_async_reset();
        test_no_found();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
